// File: rtl/input_repeater_pkg.sv
// input_repeater_pkg: shared button indices, default sizing/timing and counter helpers.
package input_repeater_pkg;

    typedef enum int unsigned {
        LEFT  = 0,
        RIGHT = 1,
        DOWN  = 2,
        CW    = 3,
        CCW   = 4
    } button_e;

    localparam int DEF_NUM_BUTTONS     = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 24;
    localparam int DEF_REPEAT_PERIOD   = 8;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce and auto-repeat for one button;
// evt is combinational and marks the edge at which a press/repeat event is taken.
module button_channel
    import input_repeater_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic held,
    output logic evt
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_last;
    logic          rep_phase;
    logic          mismatch;
    logic          toggle;
    logic          press_evt;
    logic          rep_evt;

    always_comb begin
        mismatch  = sync[1] ^ held;
        toggle    = mismatch && (db_cnt == D_LAST);
        press_evt = toggle && !held;
        rep_last  = rep_phase ? PER_LAST : DELAY_LAST;
        // A repeat due on the same edge as a release is dropped.
        rep_evt   = REPEAT_EN && held && !toggle && (rep_cnt == rep_last);
        evt       = press_evt || rep_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= '0;
            db_cnt    <= '0;
            held      <= 1'b0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            sync      <= {sync[0], raw};
            db_cnt    <= (!mismatch || toggle) ? '0 : db_cnt + DW'(1);
            held      <= held ^ toggle;
            rep_cnt   <= (!REPEAT_EN || !held || toggle || rep_evt) ? '0 : rep_cnt + RW'(1);
            rep_phase <= (held && !toggle) ? (rep_phase || rep_evt) : 1'b0;
        end
    end

endmodule

// File: rtl/input_repeater.sv
// input_repeater: per-button debounce/auto-repeat channels feeding a pending-press
// register with lowest-index-first presentation and overrun reporting.
module input_repeater
    import input_repeater_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int                     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                     REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                     REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    input  logic                   poll_inputs,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   overrun
);

    logic [NUM_BUTTONS-1:0] evt;
    logic [NUM_BUTTONS-1:0] pending;
    logic [NUM_BUTTONS-1:0] clr;
    logic [NUM_BUTTONS-1:0] pending_next;
    logic                   overrun_next;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_buttons[i]),
            .held (held[i]),
            .evt  (evt[i])
        );
    end

    always_comb begin
        // Isolate the lowest set bit.
        pressed      = pending & (~pending + NUM_BUTTONS'(1));
        clr          = poll_inputs ? pressed : '0;
        pending_next = (pending & ~clr) | evt;
        overrun_next = |(evt & pending & ~clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= pending_next;
            overrun <= overrun_next;
        end
    end

endmodule

// File: doc/input_repeater.md
INPUT_REPEATER -- requirements
Module: input_repeater

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 5, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a level change; legal range 1 or more.
REQ-003 SHALL have parameter REPEAT_DELAY, default 24, cycles from a press event to the first auto-repeat event; legal range 1 or more.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 8, cycles between subsequent auto-repeat events; legal range 1 or more.
REQ-005 SHALL have parameter REPEAT_MASK, NUM_BUTTONS bits, default all ones, channels with auto-repeat enabled.
REQ-006 clk  input  1  the single clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 raw_buttons  input  NUM_BUTTONS  asynchronous button levels, 1 = pressed.
REQ-009 poll_inputs  input  1  consumer accepts the currently presented press this cycle.
REQ-010 pressed  output  NUM_BUTTONS  one-hot or zero: the pending press to handle next.
REQ-011 held  output  NUM_BUTTONS  debounced button levels.
REQ-012 overrun  output  1  one-cycle pulse: an event merged into an already-pending, uncleared bit.

Function
REQ-013 Each channel SHALL pass raw_buttons through a 2-flop synchroniser before any other logic.
REQ-014 Debounce SHALL count consecutive cycles where the synchronised level differs from held; on any match the count SHALL clear; on the DEBOUNCE_CYCLES-th consecutive mismatch held SHALL toggle and the count SHALL clear.
REQ-015 Latency: raw high first sampled at edge 0 and held steady SHALL toggle held and set pending at edge DEBOUNCE_CYCLES+1.
REQ-016 A press event SHALL occur on the edge where held goes 0->1; a release SHALL create no event.
REQ-017 For REPEAT_MASK channels, while held stays 1, repeat events SHALL occur REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles; release SHALL clear the repeat counter immediately.
REQ-018 Channels outside REPEAT_MASK SHALL generate only press events.
REQ-019 Any event SHALL set that channel's pending bit.
REQ-020 pressed SHALL combinationally select the lowest-index pending bit; zero when nothing is pending.
REQ-021 When poll_inputs is 1, the bit shown on pressed SHALL clear at the next edge; other pending bits SHALL be unaffected.
REQ-022 An event and a poll clear on the same bit in the same cycle SHALL leave the bit set (event wins, no loss).
REQ-023 An event on a bit already pending and not being cleared that cycle SHALL leave it set and pulse overrun for exactly one cycle.
REQ-024 poll_inputs with pressed zero SHALL have no effect.
REQ-025 Counters SHALL be sized with $clog2 of their limits and SHALL saturate or reload, never wrap through zero.

Reset
REQ-026 Reset SHALL asynchronously clear synchronisers, debounce counters, repeat counters, held, pending and overrun; pressed reads zero.
REQ-027 A button held through reset release SHALL be re-accepted after the full debounce, producing a fresh press event.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abandon that activity with no event.

Structure
REQ-029 Shared package SHALL hold button index constants (LEFT=0, RIGHT=1, DOWN=2, CW=3, CCW=4), NUM_BUTTONS default and default timing constants.
REQ-030 Per-channel synchroniser, debounce and repeat logic SHALL be sub-module button_channel, generated NUM_BUTTONS times; pending, priority and overrun stay in input_repeater.

Verification
REQ-031 D=4: raw[0] high at edge 0, held -> held[0] and pressed=00001 after edge 5; poll_inputs one cycle -> pressed=00000.
REQ-032 Glitch: raw[1] high 3 cycles then low (D=4) -> held and pending never set, overrun stays 0.
REQ-033 Repeat (DELAY=24, PERIOD=8, polled every cycle): raw[2] held -> events at edges 5, 29, 37, 45; release -> no further events.
REQ-034 raw[0] and raw[3] pressed together, poll_inputs continuously -> pressed=00001 for one cycle, then 01000, then 00000.
REQ-035 Button held, no polling -> first repeat event pulses overrun once, pending stays set; event coinciding with poll of same bit -> bit remains set, overrun 0.
REQ-036 reset pulsed while raw[4] held -> outputs zero immediately; press re-accepted DEBOUNCE_CYCLES+1 edges after release.
